// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, timeout default
// and the per-cycle enable/flush bundle driven by the hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam int unsigned WAIT_W          = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
    } pipe_ctrl_t;

    // Whole pipeline advancing; optionally squash both front-end stages.
    function automatic pipe_ctrl_t ctrl_advance(input logic squash);
        pipe_ctrl_t c;
        c            = '1;
        c.flush_ifid = squash;
        c.flush_idex = squash;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous reset and clear (rst > clr > inc).
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory wait, stalls on load-use,
// squashes on taken branch, and latches a sticky timeout on a stuck memory.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load_use,
    input  logic                 i_branch_taken_ex,
    input  logic                 i_mem_busy,
    input  logic                 i_clr_cnt,
    output logic                 o_en_pc,
    output logic                 o_en_ifid,
    output logic                 o_en_idex,
    output logic                 o_en_exmem,
    output logic                 o_en_memwb,
    output logic                 o_flush_ifid,
    output logic                 o_flush_idex,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt,
    output logic                 o_mem_timeout
);

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    state_e            w_cur_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_timeout_set;
    logic              w_flush_inc;
    logic              w_stall_inc;
    pipe_ctrl_t        w_ctrl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Reset forces RUN decoding so the pipeline sees sane controls while held.
    always_comb begin
        w_ctrl        = '0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_set = 1'b0;
        w_flush_inc   = 1'b0;
        w_cur_state   = i_rst ? ST_RUN : r_state;

        case (w_cur_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (i_mem_busy) begin
                    if (w_cur_state == ST_RUN) begin
                        w_wait_nxt  = WAIT_W'(1);
                        w_state_nxt = ST_MEM_WAIT;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                        if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                            w_state_nxt   = ST_ERROR;
                            w_timeout_set = 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                    if (i_branch_taken_ex) begin
                        w_ctrl      = ctrl_advance(1'b1);
                        w_flush_inc = 1'b1;
                    end else if (i_load_use) begin
                        // Hold PC and IF/ID, push a bubble into EX.
                        w_ctrl.en_idex    = 1'b1;
                        w_ctrl.en_exmem   = 1'b1;
                        w_ctrl.en_memwb   = 1'b1;
                        w_ctrl.flush_idex = 1'b1;
                    end else begin
                        w_ctrl = ctrl_advance(1'b0);
                    end
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    assign w_stall_inc = ~w_ctrl.en_pc;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (w_stall_inc),
        .o_q   (o_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (w_flush_inc),
        .o_q   (o_flush_cnt)
    );

    assign o_en_pc       = w_ctrl.en_pc;
    assign o_en_ifid     = w_ctrl.en_ifid;
    assign o_en_idex     = w_ctrl.en_idex;
    assign o_en_exmem    = w_ctrl.en_exmem;
    assign o_en_memwb    = w_ctrl.en_memwb;
    assign o_flush_ifid  = w_ctrl.flush_ifid;
    assign o_flush_idex  = w_ctrl.flush_idex;
    assign o_mem_timeout = r_mem_timeout;

endmodule
